// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline register scoreboard (optional forwarding: SB_FORWARD_EN).
// Holds the register index width, the forward-select encodings and the producer latency classes.
package pipe_pkg;

  localparam int IDX_W = 5;

  // E-stage operand source: regfile, E/M pipeline register, M/W pipeline register
  localparam int FWD_RF = 0;
  localparam int FWD_EM = 1;
  localparam int FWD_MW = 2;

  // Minimum producer age before a consumer may leave D, by opcode group
  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2
  } lat_class_e;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: busy/age (and latency when SB_FORWARD_EN is defined) for a
// single architectural register, with issue, flush, retirement and hold handling.
module sb_entry
  import pipe_pkg::*;
#(
  parameter int SEL_W       = 2,
  parameter int WB_DEPTH    = 2,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic             i_issue,
`ifdef SB_FORWARD_EN
  input  logic [SEL_W-1:0] i_lat,
  output logic [SEL_W-1:0] o_fwd,
`endif
  output logic             o_block
);

  localparam logic [SEL_W-1:0] AGE_LAST  = SEL_W'(WB_DEPTH - 1);
  localparam logic [SEL_W-1:0] AGE_FLUSH = SEL_W'(FLUSH_DEPTH);

  logic             r_busy;
  logic [SEL_W-1:0] r_age;
  logic             w_kill;
  logic             w_retire;

  assign w_kill   = i_flush & (r_age < AGE_FLUSH);
  // At AGE_LAST the producer moves into W next; write-first regfile covers it from there
  assign w_retire = (r_age == AGE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_age  <= '0;
    end else if (!i_hold) begin
      if (i_issue) begin
        r_busy <= 1'b1;
        r_age  <= '0;
      end else if (r_busy) begin
        if (w_kill || w_retire) begin
          r_busy <= 1'b0;
          r_age  <= '0;
        end else begin
          r_age <= r_age + 1'b1;
        end
      end
    end
  end

`ifdef SB_FORWARD_EN
  logic [SEL_W-1:0] r_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat <= '0;
    end else if (!i_hold && i_issue) begin
      r_lat <= i_lat;
    end
  end

  assign o_block = r_busy & (r_age < r_lat);
  // Select k means the result sits in pipeline register k after E
  assign o_fwd   = r_busy ? (r_age + 1'b1) : '0;
`else
  assign o_block = r_busy;
`endif

endmodule

// File: rtl/pipe_scoreboard.sv
// Per-register age/latency scoreboard: decode stall plus registered E-stage forward selects.
// Forwarding is built only when SB_FORWARD_EN is defined; otherwise any busy source stalls.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int IDX_W       = pipe_pkg::IDX_W,
  parameter int WB_DEPTH    = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = $clog2(WB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_rs1_index,
  input  logic [IDX_W-1:0] id_rs2_index,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [IDX_W-1:0] id_rd_index,
  input  logic             id_wb_en,
  input  logic [SEL_W-1:0] id_lat,
  output logic             id_stall,
  output logic [SEL_W-1:0] ex_rs1_fwd_sel,
  output logic [SEL_W-1:0] ex_rs2_fwd_sel
);

  logic            w_issue;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic [NREG-1:0] w_block;

`ifdef SB_FORWARD_EN
  localparam logic [SEL_W-1:0] LAT_MAX = SEL_W'(WB_DEPTH);

  logic [SEL_W-1:0] w_lat_clamp;
  logic [SEL_W-1:0] w_fwd [NREG];
  logic [SEL_W-1:0] w_rs1_sel_nxt;
  logic [SEL_W-1:0] w_rs2_sel_nxt;
  logic [SEL_W-1:0] r_rs1_sel;
  logic [SEL_W-1:0] r_rs2_sel;

  assign w_lat_clamp = (id_lat > LAT_MAX) ? LAT_MAX : id_lat;
  assign w_fwd[0]    = '0;
`endif

  // x0 is hard-wired: never busy, never forwarded
  assign w_block[0] = 1'b0;

  assign w_rs1_haz = id_rs1_used & (id_rs1_index != '0) & w_block[id_rs1_index];
  assign w_rs2_haz = id_rs2_used & (id_rs2_index != '0) & w_block[id_rs2_index];
  assign id_stall  = id_valid & (w_rs1_haz | w_rs2_haz);
  assign w_issue   = id_valid & ~id_stall & ~flush & ~hold;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic w_wr;

    assign w_wr = w_issue & id_wb_en & (id_rd_index == IDX_W'(r));

    sb_entry #(
      .SEL_W       (SEL_W),
      .WB_DEPTH    (WB_DEPTH),
      .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .i_hold  (hold),
      .i_flush (flush),
      .i_issue (w_wr),
`ifdef SB_FORWARD_EN
      .i_lat   (w_lat_clamp),
      .o_fwd   (w_fwd[r]),
`endif
      .o_block (w_block[r])
    );
  end

`ifdef SB_FORWARD_EN
  // Non-issue cycles load regfile selects, matching the bubble entering E
  assign w_rs1_sel_nxt = (w_issue & id_rs1_used) ? w_fwd[id_rs1_index] : SEL_W'(FWD_RF);
  assign w_rs2_sel_nxt = (w_issue & id_rs2_used) ? w_fwd[id_rs2_index] : SEL_W'(FWD_RF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs1_sel <= '0;
      r_rs2_sel <= '0;
    end else if (!hold) begin
      r_rs1_sel <= w_rs1_sel_nxt;
      r_rs2_sel <= w_rs2_sel_nxt;
    end
  end

  assign ex_rs1_fwd_sel = r_rs1_sel;
  assign ex_rs2_fwd_sel = r_rs2_sel;
`else
  logic w_unused_lat;

  assign w_unused_lat   = ^id_lat;
  assign ex_rs1_fwd_sel = SEL_W'(FWD_RF);
  assign ex_rs2_fwd_sel = SEL_W'(FWD_RF);
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed pipeline scenarios with literal
// expectations plus randomized traffic against a timestamp-based model of in-flight writes.
module tb_pipe_scoreboard;

  localparam int NREG        = 32;
  localparam int IDX_W       = 5;
  localparam int WB_DEPTH    = 2;
  localparam int FLUSH_DEPTH = 1;
  localparam int SEL_W       = 2;
`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [IDX_W-1:0] id_rs1_index;
  logic [IDX_W-1:0] id_rs2_index;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [IDX_W-1:0] id_rd_index;
  logic             id_wb_en;
  logic [SEL_W-1:0] id_lat;
  logic             id_stall;
  logic [SEL_W-1:0] ex_rs1_fwd_sel;
  logic [SEL_W-1:0] ex_rs2_fwd_sel;

  int checks = 0;
  int errors = 0;

  // Model: each tracked write remembers the tick it entered E; age = elapsed non-hold ticks
  int tick = 0;
  bit m_valid [NREG];
  int m_t     [NREG];
  int m_lat   [NREG];
  int exp_sel1 = 0;
  int exp_sel2 = 0;
  bit last_stall;

  pipe_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .hold           (hold),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_rs1_index   (id_rs1_index),
    .id_rs2_index   (id_rs2_index),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd_index    (id_rd_index),
    .id_wb_en       (id_wb_en),
    .id_lat         (id_lat),
    .id_stall       (id_stall),
    .ex_rs1_fwd_sel (ex_rs1_fwd_sel),
    .ex_rs2_fwd_sel (ex_rs2_fwd_sel)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic int m_age(input int r);
    return tick - m_t[r];
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && m_valid[r] && (m_age(r) < WB_DEPTH);
  endfunction

  function automatic bit m_haz(input int idx, input bit used);
    if (!used || !m_busy(idx)) return 1'b0;
`ifdef SB_FORWARD_EN
    return m_age(idx) < m_lat[idx];
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_fwd(input int idx, input bit used);
`ifdef SB_FORWARD_EN
    if (used && m_busy(idx)) return m_age(idx) + 1;
`endif
    return 0;
  endfunction

  function automatic bit m_stall();
    return id_valid && (m_haz(int'(id_rs1_index), id_rs1_used) ||
                        m_haz(int'(id_rs2_index), id_rs2_used));
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREG; r++) m_valid[r] = 1'b0;
    exp_sel1 = 0;
    exp_sel2 = 0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input int lat, input bit h, input bit f);
    id_valid     = v;
    id_rs1_index = IDX_W'(rs1);
    id_rs1_used  = u1;
    id_rs2_index = IDX_W'(rs2);
    id_rs2_used  = u2;
    id_rd_index  = IDX_W'(rd);
    id_wb_en     = we;
    id_lat       = SEL_W'(lat);
    hold         = h;
    flush        = f;
  endtask

  task automatic drive_idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Compare at negedge, then advance the model across the coming posedge
  task automatic tick_cycle();
    bit st;
    bit iss;
    int ns1;
    int ns2;
    int clat;
    @(negedge clk);
    st = m_stall();
    chk("id_stall", id_stall, st);
    chk("rs1_fwd_sel", ex_rs1_fwd_sel, exp_sel1);
    chk("rs2_fwd_sel", ex_rs2_fwd_sel, exp_sel2);
    last_stall = id_stall;
    if (!hold) begin
      iss = id_valid && !st && !flush;
      ns1 = iss ? m_fwd(int'(id_rs1_index), id_rs1_used) : 0;
      ns2 = iss ? m_fwd(int'(id_rs2_index), id_rs2_used) : 0;
      if (flush) begin
        for (int r = 1; r < NREG; r++)
          if (m_busy(r) && m_age(r) < FLUSH_DEPTH) m_valid[r] = 1'b0;
      end
      if (iss && id_wb_en && id_rd_index != 0) begin
        clat = (int'(id_lat) > WB_DEPTH) ? WB_DEPTH : int'(id_lat);
        m_valid[id_rd_index] = 1'b1;
        m_t[id_rd_index]     = tick + 1;
        m_lat[id_rd_index]   = clat;
      end
      tick++;
      exp_sel1 = ns1;
      exp_sel2 = ns2;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until it leaves D; returns the number of stall cycles
  task automatic run_instr(input int rs1, input bit u1, input int rs2, input bit u2,
                           input int rd, input bit we, input int lat, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    drive(1'b1, rs1, u1, rs2, u2, rd, we, lat, 1'b0, 1'b0);
    for (int i = 0; i < 8 && !done; i++) begin
      tick_cycle();
      if (last_stall) stalls++;
      else done = 1'b1;
    end
    chk("issue_within_bound", int'(done), 1);
    drive_idle();
  endtask

  task automatic do_reset();
    drive(1'b1, 5, 1'b1, 6, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    chk("rst_sel1", ex_rs1_fwd_sel, 0);
    chk("rst_sel2", ex_rs2_fwd_sel, 0);
    chk("rst_stall", id_stall, 0);
    m_clear();
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int lat_load;
    lat_load = int'(pipe_pkg::LAT_LOAD);
    rst = 1'b0;
    m_clear();
    drive_idle();
    @(posedge clk);
    #1;
    do_reset();

    // add x5 ; add x6,x5,x1
    run_instr(0, 0, 0, 0, 5, 1, 0, st);
    chk("s1_producer_stalls", st, 0);
    run_instr(5, 1, 1, 1, 6, 1, 0, st);
    chk("s1_consumer_stalls", st, FWD ? 0 : 2);
    chk("s1_sel1", ex_rs1_fwd_sel, FWD ? 1 : 0);
    chk("s1_sel2", ex_rs2_fwd_sel, 0);

    // lw x5 ; add x6,x5,x5
    do_reset();
    run_instr(0, 0, 0, 0, 5, 1, lat_load, st);
    run_instr(5, 1, 5, 1, 6, 1, 0, st);
    chk("s2_load_use_stalls", st, FWD ? 1 : 2);
    chk("s2_sel1", ex_rs1_fwd_sel, FWD ? 2 : 0);
    chk("s2_sel2", ex_rs2_fwd_sel, FWD ? 2 : 0);

    // add x5 ; add x7 ; use x5   then   add x5 ; add x7 ; add x8 ; use x5
    do_reset();
    run_instr(0, 0, 0, 0, 5, 1, 0, st);
    run_instr(0, 0, 0, 0, 7, 1, 0, st);
    run_instr(5, 1, 0, 0, 9, 1, 0, st);
    chk("s3_d2_stalls", st, FWD ? 0 : 1);
    chk("s3_d2_sel1", ex_rs1_fwd_sel, FWD ? 2 : 0);
    run_instr(0, 0, 0, 0, 5, 1, 0, st);
    run_instr(0, 0, 0, 0, 7, 1, 0, st);
    run_instr(0, 0, 0, 0, 8, 1, 0, st);
    run_instr(5, 1, 0, 0, 9, 1, 0, st);
    chk("s3_d3_stalls", st, 0);
    chk("s3_d3_sel1", ex_rs1_fwd_sel, 0);

    // addi x0 ; use x0
    do_reset();
    run_instr(0, 0, 0, 0, 0, 1, 0, st);
    run_instr(0, 1, 0, 1, 6, 1, 0, st);
    chk("s4_x0_stalls", st, 0);
    chk("s4_x0_sel1", ex_rs1_fwd_sel, 0);
    chk("s4_x0_sel2", ex_rs2_fwd_sel, 0);

    // lw x9 (lat 3 clamps) ; lw x5 ; flush while x5 at age 0 and x9 at age 1
    do_reset();
    run_instr(0, 0, 0, 0, 9, 1, 3, st);
    run_instr(0, 0, 0, 0, 5, 1, lat_load, st);
    drive(1'b1, 9, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    tick_cycle();
    chk("s5_flush_cycle_stall", int'(last_stall), 1);
    run_instr(5, 1, 9, 1, 6, 1, 0, st);
    chk("s5_after_flush_stalls", st, 0);
    chk("s5_after_flush_sel1", ex_rs1_fwd_sel, 0);
    chk("s5_after_flush_sel2", ex_rs2_fwd_sel, 0);

    // lw x5 ; dependent instruction under hold for 3 cycles
    do_reset();
    run_instr(0, 0, 0, 0, 5, 1, lat_load, st);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 0, 1'b1, 1'b0);
      tick_cycle();
      chk("s6_hold_stall", int'(last_stall), 1);
      chk("s6_hold_sel1", ex_rs1_fwd_sel, 0);
    end
    run_instr(5, 1, 5, 1, 6, 1, 0, st);
    chk("s6_post_hold_stalls", st, FWD ? 1 : 2);
    chk("s6_post_hold_sel1", ex_rs1_fwd_sel, FWD ? 2 : 0);
    chk("s6_post_hold_sel2", ex_rs2_fwd_sel, FWD ? 2 : 0);

    // randomized traffic on a small register window to provoke hazards
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0);
      tick_cycle();
    end
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised register scoreboard for the in-order RISC-V pipeline. It tracks every in-flight register write from issue (D→E) to retirement, raises the decode-stage stall for load-use and multi-cycle latencies, and produces registered forwarding selects for the E-stage operand muxes. It replaces fixed index-compare hazard and forwarding logic with a per-register age/latency table, which supports any writeback depth, per-instruction result latency, branch flush and global pipeline hold.

## Interface
- `NREG`, 32: architectural register count; x0 is never tracked.
- `IDX_W`, 5: register index width.
- `WB_DEPTH`, 2: pipeline registers after E up to and including W (E/M=1, M/W=2).
- `FLUSH_DEPTH`, 1: entries with age < FLUSH_DEPTH are squashed by `flush`.
- `SEL_W`, $clog2(WB_DEPTH+1): width of the forward select and age fields.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hold`  in  1  global pipeline freeze; no state changes.
- `flush`  in  1  branch taken resolved (registered E/M branch_taken).
- `id_valid`  in  1  D stage holds a valid instruction.
- `id_rs1_index`, `id_rs2_index`  in  IDX_W  source indices.
- `id_rs1_used`, `id_rs2_used`  in  1  source actually read.
- `id_rd_index`  in  IDX_W  destination.
- `id_wb_en`  in  1  instruction writes rd.
- `id_lat`  in  SEL_W  minimum producer age for a consumer to leave D (ALU 0, load 1); values above WB_DEPTH clamp to WB_DEPTH.
- `id_stall`  out  1  hold PC and F/D; inject a bubble into D/E (combinational).
- `ex_rs1_fwd_sel`, `ex_rs2_fwd_sel`  out  SEL_W  registered; 0 = regfile, k = pipeline register k after E.

## Operation
- Per register r≠0: `busy`, `age[SEL_W]`, `lat[SEL_W]`.
- Issue = id_valid & !id_stall & !flush & !hold. On issue with id_wb_en & rd≠0, entry rd gets busy=1, age=0, lat=min(id_lat,WB_DEPTH). This overwrites any older producer of rd (WAW: the youngest producer wins).
- Every non-hold cycle, each busy entry not being re-issued does age+1. An entry whose age is WB_DEPTH−1 clears busy instead of incrementing. At age WB_DEPTH the producer is in W, and the RegFile is write-first, so the regfile read is correct.
- Source hazard for rsN: used & index≠0 & busy & age < lat.
- id_stall = id_valid & (rs1 hazard | rs2 hazard).
- Forward select captured on issue: busy ? age+1 : 0, per source. Unused sources and x0 give 0.
- On non-issue cycles without hold (stall, flush, !id_valid), both selects load 0, matching the bubble in D/E.
- flush, not during hold: every entry with age < FLUSH_DEPTH clears busy. Older entries continue normally. Flush has priority over a simultaneous issue.
- hold: table and selects frozen. id_stall stays combinationally valid.
- hold and flush together: hold wins and flush is ignored. The top level keeps flush asserted until hold drops.

## Timing
- Reset (rst=0, async): all busy=0, age=0, lat=0; ex_*_fwd_sel=0; id_stall therefore 0.
- id_stall is combinational from the D inputs plus table state, with zero latency.
- The fwd selects appear the cycle after issue, aligned with the instruction in E.
- A consumer at distance d behind a producer with latency L stalls max(0, L−d+1) cycles. With d=1 and a load (L=1), that is 1 bubble followed by sel=2.
- Reset asserted mid-operation clears everything. The first issue after release sees an empty table.

## Configuration
- `SB_FORWARD_EN` defined: behaviour as above.
- Undefined: the hazard condition becomes used & index≠0 & busy, regardless of lat. The selects are tied to 0, and the forwarding comparators and registers are not built.

## Structure
- `pipe_pkg`: IDX_W, select encodings FWD_RF=0, FWD_EM=1, FWD_MW=2, and an lat-class constant for each opcode group.
- Sub-module `sb_entry`: one register's busy/age/lat with issue, flush and hold logic. It is instantiated NREG−1 times; the top of this block does index decode and the source muxing.

## Test plan
- `add x5` issued, then `add x6,x5,x1` next cycle → no stall; ex_rs1_fwd_sel=1, ex_rs2_fwd_sel=0.
- `lw x5` (lat 1), then `add x6,x5,x5` → id_stall=1 for exactly one cycle, then issue with both selects=2.
- `add x5`, one independent instruction, then use of x5 → sel=2. With two intervening instructions → sel=0, busy cleared.
- `addi x0` followed by a use of x0 → never busy, never stalls, sel=0.
- `lw x5` issued, then flush the cycle after (age 0) → x5 entry cleared and a following use of x5 sees sel=0. An older producer at age 1 is retained.
- `lw x5` followed by a dependent instruction, with hold=1 for 3 cycles → id_stall stays 1, age stays 0. After hold drops: 1 stall cycle, then sel=2.
